// File: rtl/ram_pkg.sv
// Shared types for the self-initialising dual-port RAM.
package ram_pkg;

  // Port A behaviour when one access both reads and writes the same word.
  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } write_mode_t;

  // Initialisation sweep controller states; READY is terminal until reset.
  typedef enum logic {
    INIT,
    READY
  } init_state_t;

  localparam int unsigned MAX_READ_LATENCY = 3;

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data / read-valid pipeline of configurable depth (0 = pass-through).
module ram_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (READ_LATENCY == 0) begin : g_comb
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_q;

    // Stage 0 captures only on an accepted request, so the output holds its
    // last delivered word; later stages and the valid chain shift every cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= '0;
        for (int unsigned k = 0; k < READ_LATENCY; k++) data_q[k] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= in_data;
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
        end
      end
    end

    assign out_valid = valid_q[READ_LATENCY-1];
    assign out_data  = data_q[READ_LATENCY-1];
  end

endmodule

// File: rtl/ram_dualport_init.sv
// Simple dual-port RAM (A: read/write with byte strobes, B: read-only) that
// clears itself to INIT_VALUE after reset before accepting any traffic.
module ram_dualport_init
  import ram_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = 10,
  parameter int unsigned          DATA_WIDTH   = 64,
  parameter int unsigned          BYTE_WIDTH   = 8,
  parameter int unsigned          READ_LATENCY = 1,
  parameter write_mode_t          WRITE_MODE   = READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             init_busy,
  input  logic                             a_en,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_strobe,
  input  logic [DATA_WIDTH-1:0]            a_wdata,
  output logic [DATA_WIDTH-1:0]            a_rdata,
  output logic                             a_rvalid,
  input  logic                             b_en,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  output logic [DATA_WIDTH-1:0]            b_rdata,
  output logic                             b_rvalid
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lane_width
    $error("ram_dualport_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("ram_dualport_init: READ_LATENCY must be 0..3");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  init_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  a_acc, b_acc;
  logic [DATA_WIDTH-1:0] a_mask, a_old, a_merged, a_read_word, b_old;

  // Sweep controller state and address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance the sweep one word per cycle; leave INIT after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) state_d = READY;
      end
      READY: state_d = READY;
    endcase
  end

  assign init_busy = (state_q == INIT);
  assign a_acc     = a_en && !init_busy;
  assign b_acc     = b_en && !init_busy;

  // Expand byte strobes to a bit mask for the write-first merged word.
  always_comb begin
    a_mask = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++)
      a_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{a_strobe[i]}};
  end

  assign a_old    = mem[a_addr];
  assign b_old    = mem[b_addr];
  assign a_merged = (a_old & ~a_mask) | (a_wdata & a_mask);

  // A combinational read cannot see the same-edge write, so mode only matters with L >= 1.
  assign a_read_word = (WRITE_MODE == WRITE_FIRST && READ_LATENCY != 0) ? a_merged : a_old;

  // Memory array: sweep writes have priority; otherwise accepted strobed lanes.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (a_acc) begin
      for (int unsigned i = 0; i < NUM_LANES; i++)
        if (a_strobe[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (a_acc),
    .in_data  (a_read_word),
    .out_valid(a_rvalid),
    .out_data (a_rdata)
  );

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (b_acc),
    .in_data  (b_old),
    .out_valid(b_rvalid),
    .out_data (b_rdata)
  );

endmodule

// File: tb/tb_ram_dualport_init.sv
// Bench for ram_dualport_init: four configurations share one stimulus stream
// and are checked every cycle against a word-level reference model.
module tb_ram_dualport_init;
  import ram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam logic [63:0] INITV = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_en = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [7:0]  a_strobe = '0;
  logic [63:0] a_wdata = '0;
  logic        b_en = 1'b0;
  logic [3:0]  b_addr = '0;

  logic        busy [4];
  logic        a_rv [4];
  logic        b_rv [4];
  logic [63:0] a_rd [4];
  logic [63:0] b_rd [4];

  // k=0: L1 read-first, k=1: L2 write-first, k=2: L0, k=3: L3 read-first
  function automatic int lat_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 0;
      default: return 3;
    endcase
  endfunction

  ram_dualport_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(1),
                      .WRITE_MODE(READ_FIRST), .INIT_VALUE(INITV)) dut_l1 (
    .clk(clk), .reset(reset), .init_busy(busy[0]), .a_en(a_en), .a_addr(a_addr),
    .a_strobe(a_strobe), .a_wdata(a_wdata), .a_rdata(a_rd[0]), .a_rvalid(a_rv[0]),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[0]), .b_rvalid(b_rv[0]));

  ram_dualport_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(2),
                      .WRITE_MODE(WRITE_FIRST), .INIT_VALUE(INITV)) dut_l2wf (
    .clk(clk), .reset(reset), .init_busy(busy[1]), .a_en(a_en), .a_addr(a_addr),
    .a_strobe(a_strobe), .a_wdata(a_wdata), .a_rdata(a_rd[1]), .a_rvalid(a_rv[1]),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[1]), .b_rvalid(b_rv[1]));

  ram_dualport_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(0),
                      .WRITE_MODE(READ_FIRST), .INIT_VALUE(INITV)) dut_l0 (
    .clk(clk), .reset(reset), .init_busy(busy[2]), .a_en(a_en), .a_addr(a_addr),
    .a_strobe(a_strobe), .a_wdata(a_wdata), .a_rdata(a_rd[2]), .a_rvalid(a_rv[2]),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[2]), .b_rvalid(b_rv[2]));

  ram_dualport_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(3),
                      .WRITE_MODE(READ_FIRST), .INIT_VALUE(INITV)) dut_l3 (
    .clk(clk), .reset(reset), .init_busy(busy[3]), .a_en(a_en), .a_addr(a_addr),
    .a_strobe(a_strobe), .a_wdata(a_wdata), .a_rdata(a_rd[3]), .a_rvalid(a_rv[3]),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[3]), .b_rvalid(b_rv[3]));

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word memory, sweep progress, and per-port delivery slots
  // keyed by the cycle in which each accepted read becomes visible.
  logic [63:0] m_mem [16];
  bit          m_busy;
  int          m_cnt;
  int          cyc = 0;
  bit          m_rv [4][2];
  logic [63:0] m_rd [4][2];
  bit          pend_v [4][2][8];
  logic [63:0] pend_d [4][2][8];

  always @(posedge clk or posedge reset) begin : model
    logic [63:0] mask, old_a, old_b, merged;
    bit acc_a, acc_b;
    int slot;
    if (reset) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          m_rv[k][p] = 1'b0;
          m_rd[k][p] = '0;
          for (int s = 0; s < 8; s++) pend_v[k][p][s] = 1'b0;
        end
    end else begin
      cyc++;
      acc_a = a_en && !m_busy;
      acc_b = b_en && !m_busy;
      old_a = m_mem[a_addr];
      old_b = m_mem[b_addr];
      mask = '0;
      for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{a_strobe[i]}};
      merged = (old_a & ~mask) | (a_wdata & mask);
      for (int k = 0; k < 4; k++) begin
        if (lat_of(k) > 0) begin
          slot = (cyc + lat_of(k) - 1) % 8;
          if (acc_a) begin
            pend_v[k][0][slot] = 1'b1;
            pend_d[k][0][slot] = (k == 1) ? merged : old_a;
          end
          if (acc_b) begin
            pend_v[k][1][slot] = 1'b1;
            pend_d[k][1][slot] = old_b;
          end
        end
      end
      slot = cyc % 8;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          m_rv[k][p] = pend_v[k][p][slot];
          if (pend_v[k][p][slot]) m_rd[k][p] = pend_d[k][p][slot];
          pend_v[k][p][slot] = 1'b0;
        end
      if (m_busy) begin
        m_mem[m_cnt] = INITV;
        m_cnt++;
        if (m_cnt == 16) m_busy = 1'b0;
      end else if (acc_a) begin
        m_mem[a_addr] = merged;
      end
    end
  end

  // Every-cycle comparison of all configurations against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_busy));
        if (lat_of(k) > 0) begin
          check($sformatf("a_rvalid[%0d]", k), 64'(a_rv[k]), 64'(m_rv[k][0]));
          check($sformatf("a_rdata[%0d]", k), a_rd[k], m_rd[k][0]);
          check($sformatf("b_rvalid[%0d]", k), 64'(b_rv[k]), 64'(m_rv[k][1]));
          check($sformatf("b_rdata[%0d]", k), b_rd[k], m_rd[k][1]);
        end else begin
          check("l0_a_rvalid", 64'(a_rv[k]), 64'(a_en && !m_busy));
          if (a_en && !m_busy) check("l0_a_rdata", a_rd[k], m_mem[a_addr]);
          check("l0_b_rvalid", 64'(b_rv[k]), 64'(b_en && !m_busy));
          if (b_en && !m_busy) check("l0_b_rdata", b_rd[k], m_mem[b_addr]);
        end
      end
    end
  end

  task automatic idle(input int n);
    a_en = 1'b0;
    b_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] strb);
    a_en = 1'b1;
    a_addr = addr;
    a_wdata = data;
    a_strobe = strb;
    b_en = 1'b0;
    @(negedge clk);
    #1;
    a_en = 1'b0;
  endtask

  task automatic count_busy(input string nm);
    int nb;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy[0]) nb++;
      #1;
      a_en = (i == 5);
      a_addr = 4'd3;
      a_strobe = 8'hFF;
      a_wdata = 64'hDEAD;
    end
    a_en = 1'b0;
    check(nm, 64'(nb), 64'd16);
  endtask

  initial begin
    #1 reset = 1'b1;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Sweep length plus a write attempt while busy.
    count_busy("init_busy_cycles");

    // All words read back as INIT_VALUE on both ports.
    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1; a_strobe = '0; a_addr = 4'(i);
      b_en = 1'b1; b_addr = 4'(15 - i);
      @(negedge clk);
      check("sweep_b", b_rd[0], INITV);
      check("sweep_a", a_rd[0], INITV);
      #1;
    end
    idle(1);
    a_en = 1'b1; a_addr = 4'd3; a_strobe = '0;
    @(negedge clk);
    check("write_during_init_ignored", a_rd[0], INITV);
    #1;
    idle(1);

    // Byte-strobe merge.
    do_write(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    a_en = 1'b1; a_addr = 4'd5; a_strobe = 8'h0F; a_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    check("rf_old_word", a_rd[0], 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    a_strobe = '0;
    @(negedge clk);
    check("strobe_merge", a_rd[0], 64'hFFFF_FFFF_5566_7788);
    check("wf_merged_word", a_rd[1], 64'hFFFF_FFFF_5566_7788);
    #1;
    idle(1);

    // Back-to-back port B reads at latency 2.
    do_write(4'd1, 64'h1111, 8'hFF);
    do_write(4'd2, 64'h2222, 8'hFF);
    do_write(4'd3, 64'h3333, 8'hFF);
    idle(3);
    b_en = 1'b1; b_addr = 4'd1;
    @(negedge clk);
    check("l2_b_rvalid_early", 64'(b_rv[1]), 64'd0);
    #1 b_addr = 4'd2;
    @(negedge clk);
    check("l2_b_rvalid_1", 64'(b_rv[1]), 64'd1);
    check("l2_b_rdata_1", b_rd[1], 64'h1111);
    #1 b_addr = 4'd3;
    @(negedge clk);
    check("l2_b_rdata_2", b_rd[1], 64'h2222);
    #1 b_en = 1'b0;
    @(negedge clk);
    check("l2_b_rdata_3", b_rd[1], 64'h3333);
    #1;
    @(negedge clk);
    check("l2_b_rvalid_end", 64'(b_rv[1]), 64'd0);
    check("l2_b_rdata_hold", b_rd[1], 64'h3333);
    #1;

    // Same-edge collision on address 7.
    do_write(4'd7, 64'h55, 8'hFF);
    idle(2);
    a_en = 1'b1; a_addr = 4'd7; a_strobe = 8'hFF; a_wdata = 64'hAA;
    b_en = 1'b1; b_addr = 4'd7;
    @(negedge clk);
    check("collision_rf_a", a_rd[0], 64'h55);
    check("collision_b", b_rd[0], 64'h55);
    #1 a_en = 1'b0;
    @(negedge clk);
    check("collision_wf_a", a_rd[1], 64'hAA);
    check("collision_wf_b", b_rd[1], 64'h55);
    check("after_collision_b", b_rd[0], 64'hAA);
    #1;
    idle(2);

    // Reset with reads in flight, then reset again mid-sweep.
    a_en = 1'b1; a_addr = 4'd7; a_strobe = '0;
    b_en = 1'b1; b_addr = 4'd7;
    @(posedge clk);
    #1 reset = 1'b1;
    a_en = 1'b0; b_en = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_a_rvalid[%0d]", k), 64'(a_rv[k]), 64'd0);
      check($sformatf("reset_b_rvalid[%0d]", k), 64'(b_rv[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_sweep_busy", 64'(busy[0]), 64'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_busy("resweep_busy_cycles");
    a_en = 1'b1; a_addr = 4'd5; a_strobe = '0;
    b_en = 1'b1; b_addr = 4'd7;
    @(negedge clk);
    check("resweep_a5", a_rd[0], INITV);
    check("resweep_b7", b_rd[0], INITV);
    #1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
